// File: rtl/wb_bus_arbiter_if.sv
// Wishbone point-to-point bus bundle shared by the arbiter's master and slave sides.
// The master modport is what a bus master drives. The slave modport is what a bus slave drives.
interface wb_bus_arbiter_if #(
    parameter int addr_width   = 32,
    parameter int data_width   = 32,
    parameter int strobe_width = data_width / 8
) ();
    logic [addr_width-1:0]   adr;
    logic [data_width-1:0]   datwr;
    logic                    we;
    logic [strobe_width-1:0] sel;
    logic                    stb;
    logic                    cyc;
    logic [data_width-1:0]   datrd;
    logic                    ack;
    logic                    err;

    modport master (
        output adr, datwr, we, sel, stb, cyc,
        input  datrd, ack, err
    );

    modport slave (
        input  adr, datwr, we, sel, stb, cyc,
        output datrd, ack, err
    );
endinterface

// File: rtl/wb_bus_arbiter.sv
// Two-master, one-slave Wishbone arbiter with registered, cycle-locked grants.
// m0 is the data adapter and m1 is the instruction adapter. Arbitration is
// either round-robin or fixed priority with m0 first.
// Optional stall watchdog: define WB_ARB_TIMEOUT_EN. A granted master whose
// slave stalls for timeout_cycles cycles then gets an err pulse and loses the bus.
module wb_bus_arbiter #(
    parameter int addr_width     = 32,
    parameter int data_width     = 32,
    parameter int strobe_width   = data_width / 8,
    parameter int fixed_priority = 0,
    parameter int timeout_cycles = 255
) (
    input  logic                  clock,
    input  logic                  reset,
    wb_bus_arbiter_if.slave       m0,
    wb_bus_arbiter_if.slave       m1,
    wb_bus_arbiter_if.master      s,
    output logic [1:0]            grant
);

    // The state encoding doubles as the one-hot grant vector.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_G0   = 2'b01,
        ST_G1   = 2'b10
    } state_t;

    localparam logic use_fixed_c = (fixed_priority != 0);

    generate
        if (timeout_cycles < 2 || timeout_cycles > 65535) begin : g_bad_timeout
            $error("wb_bus_arbiter: timeout_cycles must be in 2..65535");
        end
    endgenerate

    state_t state_r;
    state_t state_nx_s;
    logic   last_grant_r;
    logic   last_grant_nx_s;
    logic   timeout_s;
    logic   granted_stb_s;

    // Choose the winner among the current requests. On a round-robin tie,
    // the master that did not hold the bus most recently wins.
    function automatic state_t arbitrate(input logic req0, input logic req1, input logic last);
        state_t win;
        if (req0 && req1) begin
            if (use_fixed_c) begin
                win = ST_G0;
            end else begin
                win = last ? ST_G0 : ST_G1;
            end
        end else if (req0) begin
            win = ST_G0;
        end else if (req1) begin
            win = ST_G1;
        end else begin
            win = ST_IDLE;
        end
        return win;
    endfunction

    // Grant state register and round-robin history.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            last_grant_r <= 1'b1;
        end else begin
            state_r      <= state_nx_s;
            last_grant_r <= last_grant_nx_s;
        end
    end

    // Next-state logic. The grant is held while cyc is up. On release, the bus
    // is handed straight to any other requester.
    always_comb begin
        state_nx_s      = state_r;
        last_grant_nx_s = last_grant_r;
        case (state_r)
            ST_IDLE: begin
                state_nx_s = arbitrate(m0.cyc, m1.cyc, last_grant_r);
            end
            ST_G0: begin
                if (timeout_s) begin
                    state_nx_s      = ST_IDLE;
                    last_grant_nx_s = 1'b0;
                end else if (!m0.cyc) begin
                    state_nx_s      = arbitrate(1'b0, m1.cyc, 1'b0);
                    last_grant_nx_s = 1'b0;
                end else begin
                    state_nx_s = ST_G0;
                end
            end
            ST_G1: begin
                if (timeout_s) begin
                    state_nx_s      = ST_IDLE;
                    last_grant_nx_s = 1'b1;
                end else if (!m1.cyc) begin
                    state_nx_s      = arbitrate(m0.cyc, 1'b0, 1'b1);
                    last_grant_nx_s = 1'b1;
                end else begin
                    state_nx_s = ST_G1;
                end
            end
            default: begin
                state_nx_s      = ST_IDLE;
                last_grant_nx_s = 1'b1;
            end
        endcase
    end

    // Strobe of the master that currently owns the bus. It drives the stall counter.
    always_comb begin
        granted_stb_s = 1'b0;
        case (state_r)
            ST_G0:   granted_stb_s = m0.stb;
            ST_G1:   granted_stb_s = m1.stb;
            default: granted_stb_s = 1'b0;
        endcase
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [15:0] timeout_last_c = 16'(timeout_cycles - 1);

    logic [15:0] stall_cnt_r;
    logic [15:0] stall_cnt_nx_s;

    // The watchdog fires on the last tolerated stall cycle, unless the slave acks in that cycle.
    always_comb begin
        if (state_r != ST_IDLE && stall_cnt_r == timeout_last_c && !s.ack) begin
            timeout_s = 1'b1;
        end else begin
            timeout_s = 1'b0;
        end
    end

    // Count stalled strobe cycles. Restart on ack, on any grant change, and while idle.
    always_comb begin
        stall_cnt_nx_s = stall_cnt_r;
        if (state_r == ST_IDLE || state_nx_s != state_r || s.ack || timeout_s) begin
            stall_cnt_nx_s = 16'd0;
        end else if (granted_stb_s) begin
            stall_cnt_nx_s = stall_cnt_r + 16'd1;
        end else begin
            stall_cnt_nx_s = stall_cnt_r;
        end
    end

    // Stall counter register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cnt_r <= 16'd0;
        end else begin
            stall_cnt_r <= stall_cnt_nx_s;
        end
    end
`else
    // Without the watchdog a stalled slave simply holds the bus.
    always_comb begin
        timeout_s = 1'b0;
    end
`endif

    // Bus steering. The granted master passes straight through to the slave,
    // and the slave ack returns only to that master. Read data goes to both
    // masters ungated.
    always_comb begin
        s.adr    = {addr_width{1'b0}};
        s.datwr  = {data_width{1'b0}};
        s.we     = 1'b0;
        s.sel    = {strobe_width{1'b0}};
        s.stb    = 1'b0;
        s.cyc    = 1'b0;
        m0.ack   = 1'b0;
        m1.ack   = 1'b0;
        m0.err   = 1'b0;
        m1.err   = 1'b0;
        m0.datrd = s.datrd;
        m1.datrd = s.datrd;
        case (state_r)
            ST_G0: begin
                s.adr   = m0.adr;
                s.datwr = m0.datwr;
                s.we    = m0.we;
                s.sel   = m0.sel;
                s.stb   = m0.stb & ~timeout_s;
                s.cyc   = m0.cyc & ~timeout_s;
                m0.ack  = s.ack;
                m0.err  = timeout_s;
            end
            ST_G1: begin
                s.adr   = m1.adr;
                s.datwr = m1.datwr;
                s.we    = m1.we;
                s.sel   = m1.sel;
                s.stb   = m1.stb & ~timeout_s;
                s.cyc   = m1.cyc & ~timeout_s;
                m1.ack  = s.ack;
                m1.err  = timeout_s;
            end
            default: begin
                s.stb = 1'b0;
                s.cyc = 1'b0;
            end
        endcase
    end

    // The grant output is the state register itself.
    always_comb begin
        grant = state_r;
    end

endmodule
